spi_pwm_multi: RTL and testbench
================================

SPI_PWM_MULTI -- requirements
Module: spi_pwm_multi

Interface
REQ-001 Parameter NUM_CH, default 8: number of PWM channels, legal range 1..8.
REQ-002 Parameter PWM_BITS, default 8: PWM counter and duty width, legal range 4..8.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active low, asynchronous to clk.
REQ-007 mosi  input  1  SPI data in, MSB first, asynchronous to clk.
REQ-008 miso  output  1  SPI read data, MSB first.
REQ-009 miso_oe  output  1  miso drive enable; 1 while the synchronised cs_n is low.
REQ-010 pwm_out  output  NUM_CH  per-channel PWM outputs.

Function
REQ-011 sclk, cs_n and mosi SHALL each pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised signals.
REQ-012 clk SHALL run at least 8x sclk; slower clk ratios are out of scope.
REQ-013 Synchronised cs_n falling edge SHALL clear the bit counter and the shift register.
REQ-014 Each synchronised sclk rising edge with cs_n low SHALL shift mosi in; a 16-bit frame is bit15=R/W (1=write), bits14:8=address, bits7:0=data.
REQ-015 Write SHALL commit on the clk cycle after the 16th sampled rising edge; sclk edges after the 16th SHALL be ignored until the next cs_n falling edge.
REQ-016 A frame ended by cs_n rising with fewer than 16 bits SHALL be discarded, with no register change.
REQ-017 Register map: 0x00 out_en[NUM_CH-1:0]; 0x01 pwm_mode[NUM_CH-1:0]; 0x02 prescale[7:0]; 0x10+i duty[i][PWM_BITS-1:0] for i<NUM_CH.
REQ-018 Writes to unmapped addresses SHALL be ignored, and reads from them SHALL return 0x00.
REQ-019 Unimplemented bits SHALL read as 0, and writes to them SHALL be ignored.
REQ-020 On a read frame (bit15=0), the addressed register SHALL be latched after the 8th rising edge.
REQ-021 During a read frame, miso SHALL present data bit7 immediately and shift to the next bit on each following synchronised sclk falling edge.
REQ-022 miso SHALL be 0 during bits 15..8 of every frame and throughout write frames.
REQ-023 The prescaler SHALL issue one tick every (prescale+1) clk cycles; prescale=0 means a tick every cycle.
REQ-024 The PWM counter SHALL advance on each tick over 0..MAX-1, where MAX=2^PWM_BITS-1, and wrap to 0.
REQ-025 Each channel SHALL hold a shadow duty_act[i], loaded from duty[i] only on the tick where the counter wraps from MAX-1 to 0.
REQ-026 pwm_out[i] SHALL equal out_en[i] AND (pwm_mode[i] ? (counter < duty_act[i]) : 1), and SHALL be registered (one clk latency).
REQ-027 Duty boundaries: duty_act=0 gives a constant low output; duty_act=MAX gives a constant high output.
REQ-028 A write to prescale SHALL take effect on the next prescaler reload; the prescaler count SHALL NOT be reset by the write.
REQ-029 If a write commit and a shadow load fall in the same cycle, the shadow SHALL take the pre-write duty, and the new value SHALL apply from the next period.

Reset
REQ-030 While rst=1, all registers, duty_act, the PWM counter, the prescaler, the bit counter and the shift register SHALL be 0.
REQ-031 While rst=1, pwm_out, miso and miso_oe SHALL be 0.
REQ-032 Synchroniser flops SHALL reset to the idle state: cs_n=1, sclk=0.
REQ-033 Asserting rst mid-frame SHALL abort the frame; the next frame SHALL begin only at a fresh cs_n falling edge.

Verification
REQ-034 Reset, then write 0x00=0x01, 0x01=0x01, 0x10=0x80 with PWM_BITS=8 and prescale=0 -> pwm_out[0] high for 128 of every 255 clk cycles once the next period starts.
REQ-035 Duty boundaries: duty=0x00 -> pwm_out[0] constant 0; duty=0xFF -> pwm_out[0] constant 1; out_en=1 with pwm_mode=0 -> constant 1.
REQ-036 Write 0x10=0x40 mid-period -> output keeps the old duty until counter wrap, then the high time is 64 cycles; no glitch within the period.
REQ-037 Write 0x02=0x03, then read 0x02 -> PWM period is 4*255 clk cycles, and miso shifts out 0x03 MSB first on bits 7..0.
REQ-038 Send a 10-bit frame, raise cs_n, then read 0x10 -> value unchanged; reading unmapped 0x7F returns 0x00.
REQ-039 Assert rst for one cycle at bit 9 of a write frame -> all outputs 0, register unchanged from reset, and the next full frame is accepted normally.

Source files
------------

// File: rtl/spi_pwm_multi_if.sv
// rtl/spi_pwm_multi_if.sv - SPI register bus between a host and the PWM block
interface spi_pwm_multi_if;
   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
   modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_pwm_multi.sv
// rtl/spi_pwm_multi.sv - SPI mode-0 register slave driving NUM_CH shadowed PWM channels
module spi_pwm_multi #(
   parameter int NUM_CH   = 8,
   parameter int PWM_BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   spi_pwm_multi_if.slave    spi,
   output logic [NUM_CH-1:0] pwm_out
);

   localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t state, state_nx;

   logic [1:0] sclk_sy, cs_sy, mosi_sy;
   logic       sclk_d, cs_d;
   logic       sclk_s, cs_s, mosi_s;
   logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [1:0] settle;
   logic       armed;
   logic       frame_start, shift_en;
   logic [4:0] bit_cnt;
   logic [15:0] shreg;
   logic       wr_pend, rd_pend;
   logic [7:0] rd_val, rd_sh;
   logic       rd_active;

   logic [NUM_CH-1:0]   out_en, pwm_mode;
   logic [7:0]          prescale, pre_cnt;
   logic [PWM_BITS-1:0] duty [8];
   logic [PWM_BITS-1:0] duty_act [NUM_CH];
   logic [PWM_BITS-1:0] cnt;
   logic                tick, wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sy <= 2'b00;
         cs_sy   <= 2'b11;
         mosi_sy <= 2'b00;
         sclk_d  <= 1'b0;
         cs_d    <= 1'b1;
      end else begin
         sclk_sy <= {sclk_sy[0], spi.sclk};
         cs_sy   <= {cs_sy[0], spi.cs_n};
         mosi_sy <= {mosi_sy[0], spi.mosi};
         sclk_d  <= sclk_sy[1];
         cs_d    <= cs_sy[1];
      end
   end

   assign sclk_s    = sclk_sy[1];
   assign cs_s      = cs_sy[1];
   assign mosi_s    = mosi_sy[1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   // The synchroniser resets to cs_n=1, so a host already holding cs_n low would
   // look like a fresh falling edge; only arm once a settled cs_n high is seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle <= 2'd0;
         armed  <= 1'b0;
      end else begin
         if (settle != 2'd3)
            settle <= settle + 2'd1;
         if (settle == 2'd3 && cs_s)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      frame_start = 1'b0;
      shift_en    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cs_fall && armed) begin
               state_nx    = ST_SHIFT;
               frame_start = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_nx = ST_IDLE;
            end else if (sclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == 5'd15)
                  state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            if (cs_rise)
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= 5'd0;
         shreg   <= 16'h0000;
         wr_pend <= 1'b0;
         rd_pend <= 1'b0;
      end else begin
         wr_pend <= shift_en && (bit_cnt == 5'd15);
         rd_pend <= shift_en && (bit_cnt == 5'd7);
         if (frame_start) begin
            bit_cnt <= 5'd0;
            shreg   <= 16'h0000;
         end else if (shift_en) begin
            shreg   <= {shreg[14:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

   // After eight bits the low byte of the shift register holds {R/W, address}.
   always_comb begin
      rd_val = 8'h00;
      if (shreg[6:0] == 7'h00)
         rd_val[NUM_CH-1:0] = out_en;
      else if (shreg[6:0] == 7'h01)
         rd_val[NUM_CH-1:0] = pwm_mode;
      else if (shreg[6:0] == 7'h02)
         rd_val = prescale;
      else if (shreg[6:3] == 4'h2 && {1'b0, shreg[2:0]} < 4'(NUM_CH))
         rd_val[PWM_BITS-1:0] = duty[shreg[2:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_en   <= '0;
         pwm_mode <= '0;
         prescale <= 8'h00;
         for (int i = 0; i < 8; i++)
            duty[i] <= '0;
      end else if (wr_pend && shreg[15]) begin
         if (shreg[14:8] == 7'h00)
            out_en <= shreg[NUM_CH-1:0];
         else if (shreg[14:8] == 7'h01)
            pwm_mode <= shreg[NUM_CH-1:0];
         else if (shreg[14:8] == 7'h02)
            prescale <= shreg[7:0];
         else if (shreg[14:11] == 4'h2 && {1'b0, shreg[10:8]} < 4'(NUM_CH))
            duty[shreg[10:8]] <= shreg[PWM_BITS-1:0];
      end
   end

   // Bit 7 is held through the 8th falling edge; shifting starts once the
   // host has sampled it on the 9th rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_sh     <= 8'h00;
         rd_active <= 1'b0;
      end else if (frame_start || cs_rise) begin
         rd_sh     <= 8'h00;
         rd_active <= 1'b0;
      end else if (rd_pend && !shreg[7]) begin
         rd_sh     <= rd_val;
         rd_active <= 1'b1;
      end else if (sclk_fall && rd_active && bit_cnt >= 5'd9) begin
         rd_sh <= {rd_sh[6:0], 1'b0};
      end
   end

   assign spi.miso    = rd_active & rd_sh[7];
   assign spi.miso_oe = ~cs_s;

   assign tick = (pre_cnt == 8'h00);
   assign wrap = tick && (cnt == CNT_LAST);

   // Reloading from prescale only on a tick lets a new value land without
   // disturbing the count already in progress.
   always_ff @(posedge clk) begin
      if (rst)
         pre_cnt <= 8'h00;
      else if (tick)
         pre_cnt <= prescale;
      else
         pre_cnt <= pre_cnt - 8'h01;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (tick)
         cnt <= wrap ? '0 : cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++)
            duty_act[i] <= '0;
         pwm_out <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wrap)
               duty_act[i] <= duty[i];
            pwm_out[i] <= out_en[i] & (pwm_mode[i] ? (cnt < duty_act[i]) : 1'b1);
         end
      end
   end

endmodule

// File: tb/tb_spi_pwm_multi.sv
// tb/tb_spi_pwm_multi.sv - directed bench for spi_pwm_multi (4 channels, 8-bit PWM)
module tb_spi_pwm_multi;

   localparam int NCH  = 4;
   localparam int HALF = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] pwm_out;
   int             checks = 0;
   int             errors = 0;

   spi_pwm_multi_if sif ();

   spi_pwm_multi #(.NUM_CH(NCH), .PWM_BITS(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .spi     (sif.slave),
      .pwm_out (pwm_out)
   );

   initial forever #5 clk = ~clk;

   task automatic spi_xfer(input logic [15:0] word, input int nbits, input int rst_bit,
                           output logic [7:0] rd, output logic hi, output logic oe_mid,
                           output logic [NCH+1:0] snap);
      rd = 8'h00; hi = 1'b0; oe_mid = 1'b0; snap = '1;
      @(negedge clk);
      sif.cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         sif.mosi = word[15-i];
         if (i == rst_bit) begin
            rst = 1'b1;
            @(negedge clk);
            snap = {pwm_out, sif.miso, sif.miso_oe};
            rst = 1'b0;
         end
         repeat (HALF) @(negedge clk);
         if (i == 4) oe_mid = sif.miso_oe;
         if (i < 8 || word[15]) begin
            if (sif.miso !== 1'b0) hi = 1'b1;
         end else begin
            rd = {rd[6:0], sif.miso};
         end
         sif.sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sif.sclk = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      sif.cs_n = 1'b1;
      sif.mosi = 1'b0;
      repeat (2*HALF) @(negedge clk);
   endtask

   task automatic spi_write(input logic [6:0] addr, input logic [7:0] data, output logic hi);
      logic [7:0] rd; logic oe; logic [NCH+1:0] snap;
      spi_xfer({1'b1, addr, data}, 16, -1, rd, hi, oe, snap);
   endtask

   task automatic spi_read(input logic [6:0] addr, output logic [7:0] rd, output logic hi);
      logic oe; logic [NCH+1:0] snap;
      spi_xfer({1'b0, addr, 8'h00}, 16, -1, rd, hi, oe, snap);
   endtask

   task automatic wait_rise(output logic ok);
      logic prev;
      ok = 1'b0;
      prev = pwm_out[0];
      for (int n = 0; n < 5000 && !ok; n++) begin
         @(negedge clk);
         if (!prev && pwm_out[0]) ok = 1'b1;
         prev = pwm_out[0];
      end
   endtask

   // Called on the first high sample of a period; returns high time and rise-to-rise period.
   task automatic measure_period(output int high, output int period);
      logic prev;
      high = 1; period = 1; prev = 1'b1;
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         if (!prev && pwm_out[0]) break;
         period++;
         if (pwm_out[0]) high++;
         prev = pwm_out[0];
      end
   endtask

   task automatic test_reset();
      logic [7:0] rd; logic hi;
      rst = 1'b1; sif.cs_n = 1'b1; sif.sclk = 1'b0; sif.mosi = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (pwm_out !== '0) begin errors++; $display("FAIL reset_pwm got %0h expected 0", pwm_out); end
      checks++; if (sif.miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %0b expected 0", sif.miso); end
      checks++; if (sif.miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %0b expected 0", sif.miso_oe); end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      spi_read(7'h00, rd, hi);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_out_en got %0h expected 00", rd); end
      spi_read(7'h10, rd, hi);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_duty0 got %0h expected 00", rd); end
      spi_read(7'h02, rd, hi);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_prescale got %0h expected 00", rd); end
   endtask

   task automatic test_basic();
      logic [7:0] rd; logic hi, hi_any, oe; logic [NCH+1:0] snap;
      int high, edges; logic prev;
      spi_xfer({1'b1, 7'h00, 8'h01}, 16, -1, rd, hi_any, oe, snap);
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL oe_in_frame got %0b expected 1", oe); end
      checks++; if (sif.miso_oe !== 1'b0) begin errors++; $display("FAIL oe_after_frame got %0b expected 0", sif.miso_oe); end
      spi_write(7'h01, 8'h01, hi); hi_any |= hi;
      spi_write(7'h10, 8'h80, hi); hi_any |= hi;
      checks++; if (hi_any !== 1'b0) begin errors++; $display("FAIL miso_write_frame got %0b expected 0", hi_any); end
      repeat (600) @(negedge clk);
      high = 0; edges = 0; prev = pwm_out[0];
      for (int n = 0; n < 255; n++) begin
         @(negedge clk);
         if (pwm_out[0]) high++;
         if (!prev && pwm_out[0]) edges++;
         prev = pwm_out[0];
      end
      checks++; if (high != 128) begin errors++; $display("FAIL duty80_high got %0d expected 128", high); end
      checks++; if (edges != 1) begin errors++; $display("FAIL duty80_edges got %0d expected 1", edges); end
      high = 0;
      for (int n = 0; n < 510; n++) begin
         @(negedge clk);
         if (pwm_out[0]) high++;
      end
      checks++; if (high != 256) begin errors++; $display("FAIL duty80_two_periods got %0d expected 256", high); end
      checks++; if (pwm_out[NCH-1:1] !== '0) begin errors++; $display("FAIL other_channels got %0h expected 0", pwm_out[NCH-1:1]); end
      spi_read(7'h10, rd, hi);
      checks++; if (rd !== 8'h80) begin errors++; $display("FAIL readback_duty0 got %0h expected 80", rd); end
      checks++; if (hi !== 1'b0) begin errors++; $display("FAIL miso_addr_phase got %0b expected 0", hi); end
   endtask

   task automatic test_boundaries();
      logic hi; int high;
      logic [7:0] duty_v [3];
      logic [7:0] mode_v [3];
      int         exp_v  [3];
      duty_v = '{8'h00, 8'hFF, 8'h00};
      mode_v = '{8'h01, 8'h01, 8'h00};
      exp_v  = '{0, 255, 255};
      for (int k = 0; k < 3; k++) begin
         spi_write(7'h10, duty_v[k], hi);
         spi_write(7'h01, mode_v[k], hi);
         repeat (600) @(negedge clk);
         high = 0;
         for (int n = 0; n < 255; n++) begin
            @(negedge clk);
            if (pwm_out[0]) high++;
         end
         checks++;
         if (high != exp_v[k]) begin
            errors++;
            $display("FAIL boundary_%0d got %0d expected %0d", k, high, exp_v[k]);
         end
      end
      spi_write(7'h01, 8'h01, hi);
      spi_write(7'h10, 8'h80, hi);
      repeat (600) @(negedge clk);
   endtask

   task automatic test_prescale_read();
      logic [7:0] rd; logic hi, ok; int high, period;
      spi_write(7'h02, 8'h03, hi);
      spi_read(7'h02, rd, hi);
      checks++; if (rd !== 8'h03) begin errors++; $display("FAIL read_prescale got %0h expected 03", rd); end
      checks++; if (hi !== 1'b0) begin errors++; $display("FAIL read_prescale_hdr got %0b expected 0", hi); end
      wait_rise(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL prescale_rise_timeout got %0b expected 1", ok); end
      measure_period(high, period);
      checks++; if (period != 1020) begin errors++; $display("FAIL prescale_period got %0d expected 1020", period); end
      checks++; if (high != 512) begin errors++; $display("FAIL prescale_high got %0d expected 512", high); end
   endtask

   task automatic test_mid_period();
      logic hi, ok; int high, period, cur_high;
      wait_rise(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_rise_timeout got %0b expected 1", ok); end
      cur_high = 1;
      fork
         spi_write(7'h10, 8'h40, hi);
         begin
            for (int n = 0; n < 5000; n++) begin
               @(negedge clk);
               if (!pwm_out[0]) break;
               cur_high++;
            end
         end
      join
      checks++; if (cur_high != 512) begin errors++; $display("FAIL mid_old_duty_high got %0d expected 512", cur_high); end
      wait_rise(ok);
      measure_period(high, period);
      checks++; if (high != 256) begin errors++; $display("FAIL mid_new_duty_high got %0d expected 256", high); end
      checks++; if (period != 1020) begin errors++; $display("FAIL mid_period got %0d expected 1020", period); end
   endtask

   task automatic test_map();
      logic [7:0] rd; logic hi, oe; logic [NCH+1:0] snap;
      spi_xfer(16'h9011, 10, -1, rd, hi, oe, snap);
      spi_read(7'h10, rd, hi);
      checks++; if (rd !== 8'h40) begin errors++; $display("FAIL short_frame_duty got %0h expected 40", rd); end
      spi_read(7'h7F, rd, hi);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL read_7f got %0h expected 00", rd); end
      spi_write(7'h7F, 8'hAA, hi);
      spi_read(7'h7F, rd, hi);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL write_7f got %0h expected 00", rd); end
      spi_write(7'h14, 8'h55, hi);
      spi_read(7'h14, rd, hi);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL duty_past_last got %0h expected 00", rd); end
      spi_write(7'h13, 8'h5A, hi);
      spi_read(7'h13, rd, hi);
      checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL duty_last got %0h expected 5a", rd); end
      spi_write(7'h00, 8'hFF, hi);
      spi_read(7'h00, rd, hi);
      checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL out_en_width got %0h expected 0f", rd); end
   endtask

   task automatic test_rst_mid_frame();
      logic [7:0] rd; logic hi, oe, any_hi; logic [NCH+1:0] snap;
      spi_xfer(16'h9022, 16, 9, rd, hi, oe, snap);
      checks++; if (snap !== '0) begin errors++; $display("FAIL rst_outputs got %0h expected 0", snap); end
      any_hi = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (pwm_out !== '0) any_hi = 1'b1;
      end
      checks++; if (any_hi !== 1'b0) begin errors++; $display("FAIL rst_pwm_idle got %0b expected 0", any_hi); end
      spi_read(7'h10, rd, hi);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_duty0 got %0h expected 00", rd); end
      spi_read(7'h00, rd, hi);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_out_en got %0h expected 00", rd); end
      spi_read(7'h02, rd, hi);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_prescale got %0h expected 00", rd); end
      spi_write(7'h10, 8'h22, hi);
      spi_read(7'h10, rd, hi);
      checks++; if (rd !== 8'h22) begin errors++; $display("FAIL post_rst_write got %0h expected 22", rd); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_prescale_read();
      test_mid_period();
      test_map();
      test_rst_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
